hls_run_sequencer: RTL and testbench

- Synthesizable run controller that drives the start/done handshake of an HLS-generated top (`main`).
- Consumes that top's 32-bit return value (the checksum).
- Launches NUM_RUNS back-to-back executions and measures the latency of each.
- Checks every run's checksum against run 0 (determinism) and against an externally supplied golden value. Exposes a single pass/fail summary for fuzzing benches and FPGA harnesses.

---
 rtl/hls_run_sequencer.sv | 143 ++++++++++++++
 tb/tb_hls_run_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// Run controller for an HLS top: launches NUM_RUNS start/done runs, times them,
// and checks checksums against run 0 and a golden value. Watchdog: HLS_RUN_TIMEOUT_EN.
module hls_run_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_RUNS       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] golden_checksum,
  output logic                  dut_start_port,
  input  logic                  dut_done_port,
  input  logic [DATA_WIDTH-1:0] dut_return_port,
  output logic                  busy,
  output logic [7:0]            run_index,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_checksum,
  output logic [CNT_WIDTH-1:0]  result_cycles,
  output logic                  finished,
  output logic                  pass,
  output logic                  mismatch_golden,
  output logic                  mismatch_runs,
  output logic                  timeout_flag
);

  generate
    if (NUM_RUNS < 1 || NUM_RUNS > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("hls_run_sequencer: NUM_RUNS must be 1..256, TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CAPTURE, S_FINISHED
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] golden_q;
  logic [DATA_WIDTH-1:0] ref_q;
  logic                  mg_next;
  logic                  mr_next;
  logic                  last_run;

  // latency counter saturates at all-ones
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  assign last_run = (run_index == 8'(NUM_RUNS - 1));
  assign mr_next  = mismatch_runs |
                    ((run_index != 8'd0) && (result_checksum != ref_q));
  assign mg_next  = mismatch_golden | (result_checksum != golden_q);

`ifdef HLS_RUN_TIMEOUT_EN
  logic to_hit;
  assign to_hit = (cnt_inc >= CNT_WIDTH'(TIMEOUT_CYCLES));
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      golden_q        <= '0;
      ref_q           <= '0;
      dut_start_port  <= 1'b0;
      busy            <= 1'b0;
      run_index       <= 8'd0;
      result_valid    <= 1'b0;
      result_checksum <= '0;
      result_cycles   <= '0;
      finished        <= 1'b0;
      pass            <= 1'b0;
      mismatch_golden <= 1'b0;
      mismatch_runs   <= 1'b0;
`ifdef HLS_RUN_TIMEOUT_EN
      timeout_flag    <= 1'b0;
`endif
    end else begin
      dut_start_port <= 1'b0;
      result_valid   <= 1'b0;
      unique case (state)
        S_IDLE, S_FINISHED: begin
          if (go) begin
            golden_q        <= golden_checksum;
            mismatch_golden <= 1'b0;
            mismatch_runs   <= 1'b0;
`ifdef HLS_RUN_TIMEOUT_EN
            timeout_flag    <= 1'b0;
`endif
            finished        <= 1'b0;
            pass            <= 1'b0;
            run_index       <= 8'd0;
            busy            <= 1'b1;
            dut_start_port  <= 1'b1;
            state           <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (dut_done_port) begin
            result_checksum <= dut_return_port;
            result_cycles   <= cnt_inc;
            result_valid    <= 1'b1;
            state           <= S_CAPTURE;
          end
`ifdef HLS_RUN_TIMEOUT_EN
          else if (to_hit) begin
            timeout_flag  <= 1'b1;
            result_cycles <= CNT_WIDTH'(TIMEOUT_CYCLES);
            busy          <= 1'b0;
            finished      <= 1'b1;
            pass          <= 1'b0;
            state         <= S_FINISHED;
          end
`endif
        end
        S_CAPTURE: begin
          if (run_index == 8'd0) ref_q <= result_checksum;
          mismatch_runs   <= mr_next;
          mismatch_golden <= mg_next;
          if (last_run) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            pass     <= !mg_next && !mr_next && !timeout_flag;
            state    <= S_FINISHED;
          end else begin
            run_index      <= run_index + 8'd1;
            dut_start_port <= 1'b1;
            state          <= S_START;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer with a behavioural HLS-top model.
// Define HLS_RUN_TIMEOUT_EN to also exercise the watchdog.
module tb_hls_run_sequencer;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int NR = 4;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          go;
  logic [DW-1:0] golden_checksum;
  logic          dut_start_port;
  logic          dut_done_port;
  logic [DW-1:0] dut_return_port;
  logic          busy;
  logic [7:0]    run_index;
  logic          result_valid;
  logic [DW-1:0] result_checksum;
  logic [CW-1:0] result_cycles;
  logic          finished;
  logic          pass;
  logic          mismatch_golden;
  logic          mismatch_runs;
  logic          timeout_flag;

  hls_run_sequencer #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .NUM_RUNS(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .go(go),
    .golden_checksum(golden_checksum),
    .dut_start_port(dut_start_port),
    .dut_done_port(dut_done_port),
    .dut_return_port(dut_return_port),
    .busy(busy), .run_index(run_index),
    .result_valid(result_valid),
    .result_checksum(result_checksum),
    .result_cycles(result_cycles),
    .finished(finished), .pass(pass),
    .mismatch_golden(mismatch_golden),
    .mismatch_runs(mismatch_runs),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // model knobs, written only by the main sequence
  int            lat   = 5;
  bit            hold  = 1'b0;
  bit            never = 1'b0;
  logic [DW-1:0] ret_tbl [NR];

  // monitor: cycle numbers of start pulses, per-run results
  int            cyc = 0;
  int            start_q [$];
  int            rc_q [$];
  logic [DW-1:0] rs_q [$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (dut_start_port) start_q.push_back(cyc);
    if (result_valid) begin
      rc_q.push_back(int'(result_cycles));
      rs_q.push_back(result_checksum);
    end
  end

  // HLS top model: done 'lat' cycles after the start pulse
  initial begin
    int countdown;
    countdown       = 0;
    dut_done_port   = 1'b0;
    dut_return_port = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        countdown     = 0;
        dut_done_port = 1'b0;
      end else begin
        if (countdown > 0) begin
          countdown = countdown - 1;
          if (countdown == 0) begin
            dut_done_port   = 1'b1;
            dut_return_port = ret_tbl[run_index % NR];
          end
        end else if (!hold) begin
          dut_done_port = 1'b0;
        end
        if (dut_start_port && !never) countdown = lat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  int sb;
  int rb;

  task automatic launch(logic [DW-1:0] g);
    @(negedge clock);
    sb              = start_q.size();
    rb              = rc_q.size();
    golden_checksum = g;
    go              = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_finished(string tag, int budget);
    int n;
    n = 0;
    while (!finished && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, " finish"}, 64'(finished), 64'd1);
  endtask

  task automatic check_zero(string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " start"}, 64'(dut_start_port), 64'd0);
    check({tag, " run_index"}, 64'(run_index), 64'd0);
    check({tag, " valid"}, 64'(result_valid), 64'd0);
    check({tag, " checksum"}, 64'(result_checksum), 64'd0);
    check({tag, " cycles"}, 64'(result_cycles), 64'd0);
    check({tag, " finished"}, 64'(finished), 64'd0);
    check({tag, " pass"}, 64'(pass), 64'd0);
    check({tag, " mm_golden"}, 64'(mismatch_golden), 64'd0);
    check({tag, " mm_runs"}, 64'(mismatch_runs), 64'd0);
    check({tag, " timeout"}, 64'(timeout_flag), 64'd0);
  endtask

  task automatic check_campaign(string tag, int spacing, int cycles,
                                bit mg, bit mr, bit ps);
    check({tag, " starts"}, 64'(start_q.size() - sb), 64'(NR));
    check({tag, " results"}, 64'(rc_q.size() - rb), 64'(NR));
    for (int i = sb + 1; i < start_q.size(); i++)
      check({tag, " spacing"}, 64'(start_q[i] - start_q[i-1]), 64'(spacing));
    for (int i = rb; i < rc_q.size(); i++)
      check({tag, " run_cycles"}, 64'(rc_q[i]), 64'(cycles));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " run_index"}, 64'(run_index), 64'(NR - 1));
    check({tag, " mm_golden"}, 64'(mismatch_golden), 64'(mg));
    check({tag, " mm_runs"}, 64'(mismatch_runs), 64'(mr));
    check({tag, " timeout"}, 64'(timeout_flag), 64'd0);
    check({tag, " pass"}, 64'(pass), 64'(ps));
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    go              = 1'b0;
    golden_checksum = '0;
    for (int i = 0; i < NR; i++) ret_tbl[i] = 32'hDEADBEEF;
    tick(2);
    check_zero("reset");
    reset = 1'b0;
    tick(2);

    // clean campaign, with a stray go while busy
    launch(32'hDEADBEEF);
    check("A busy", 64'(busy), 64'd1);
    check("A start", 64'(dut_start_port), 64'd1);
    tick(3);
    golden_checksum = 32'h0;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_finished("A", 200);
    check_campaign("A", 7, 5, 1'b0, 1'b0, 1'b1);
    check("A checksum", 64'(result_checksum), 64'hDEADBEEF);
    tick(3);

    // run 2 diverges by one bit
    ret_tbl[2] = 32'hDEADBEEE;
    launch(32'hDEADBEEF);
    wait_finished("B", 200);
    check_campaign("B", 7, 5, 1'b1, 1'b1, 1'b0);
    check("B run2 sum", 64'(rs_q[rb+2]), 64'hDEADBEEE);
    tick(3);

    // deterministic but wrong against golden
    for (int i = 0; i < NR; i++) ret_tbl[i] = 32'h12345678;
    launch(32'hDEADBEEF);
    wait_finished("C", 200);
    check_campaign("C", 7, 5, 1'b1, 1'b0, 1'b0);
    tick(3);

    // done in first WAIT cycle and held high through CAPTURE/START
    for (int i = 0; i < NR; i++) ret_tbl[i] = 32'hDEADBEEF;
    lat  = 1;
    hold = 1'b1;
    launch(32'hDEADBEEF);
    wait_finished("D", 200);
    check_campaign("D", 3, 1, 1'b0, 1'b0, 1'b1);
    hold = 1'b0;
    tick(6);
    check("D no extra run", 64'(start_q.size() - sb), 64'(NR));

    // reset during WAIT of run 1, then a clean campaign
    lat = 5;
    launch(32'hDEADBEEF);
    n = 0;
    while ((start_q.size() - sb) < 2 && n < 50) begin
      tick(1);
      n++;
    end
    check("E reach run1", 64'(start_q.size() - sb), 64'd2);
    tick(2);
    check("E in run1", 64'(run_index), 64'd1);
    reset = 1'b1;
    tick(1);
    check_zero("E after reset");
    tick(1);
    reset = 1'b0;
    tick(2);
    launch(32'hDEADBEEF);
    wait_finished("E2", 200);
    check_campaign("E2", 7, 5, 1'b0, 1'b0, 1'b1);
    tick(3);

`ifdef HLS_RUN_TIMEOUT_EN
    // DUT never completes
    never = 1'b1;
    launch(32'hDEADBEEF);
    wait_finished("T", 400);
    check("T timeout", 64'(timeout_flag), 64'd1);
    check("T pass", 64'(pass), 64'd0);
    check("T busy", 64'(busy), 64'd0);
    check("T cycles", 64'(result_cycles), 64'(TO));
    check("T results", 64'(rc_q.size() - rb), 64'd0);
    check("T starts", 64'(start_q.size() - sb), 64'd1);
    never = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
